// File: rtl/bp_update_unit.sv
// Branch predictor resolution end: in-order queue of prediction records popped by EX,
// producing counter/target update writes, mispredict flush/redirect and a mispredict count.
module bp_update_unit #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pred_valid,
   input  logic [31:0]      pred_pc,
   input  logic             pred_taken,
   input  logic [31:0]      pred_target,
   input  logic [1:0]       pred_ctr,
   output logic             pred_ready,
   input  logic             res_valid,
   input  logic             res_taken,
   input  logic [31:0]      res_target,
   output logic             res_ready,
   output logic             upd_write,
   output logic [31:0]      upd_waddr,
   output logic [1:0]       upd_ctr,
   output logic             upd_tgt_write,
   output logic [31:0]      upd_target,
   output logic             flush,
   output logic [31:0]      redirect_pc,
   output logic [CNT_W-1:0] mispredict_cnt,
   output logic             err_underflow
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int QC_W  = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
      logic [1:0]  ctr;
   } entry_t;

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] head_q, tail_q;
   logic [QC_W-1:0]  count_q;

   entry_t head_p0;
   logic   pop_p0, push_p0, tgt_diff_p0, mispredict_p0, flush_next;

   function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
      if (taken)
         return (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
      return (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
   endfunction

   function automatic logic [CNT_W-1:0] sat_cnt_inc(input logic [CNT_W-1:0] cnt);
      return (&cnt) ? cnt : cnt + CNT_W'(1);
   endfunction

   // Stage p0: resolve against the head record
   assign pred_ready    = (count_q != QC_W'(DEPTH));
   assign res_ready     = (count_q != '0);
   assign head_p0       = mem_q[head_q];
   assign pop_p0        = res_valid && res_ready;
   assign tgt_diff_p0   = (res_target != head_p0.target);
   assign mispredict_p0 = (res_taken != head_p0.taken) ||
                          (res_taken && head_p0.taken && tgt_diff_p0);
   assign flush_next    = pop_p0 && mispredict_p0;
   // Wrong-path pushes are discarded while a flush is being decided or signalled
   assign push_p0       = pred_valid && pred_ready && !flush_next && !flush;

   always_ff @(posedge clk) begin
      if (push_p0)
         mem_q[tail_q] <= entry_t'{pc: pred_pc, taken: pred_taken,
                                   target: pred_target, ctr: pred_ctr};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (flush_next) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_p0)
            tail_q <= tail_q + PTR_W'(1);
         if (pop_p0)
            head_q <= head_q + PTR_W'(1);
         case ({push_p0, pop_p0})
            2'b10:   count_q <= count_q + QC_W'(1);
            2'b01:   count_q <= count_q - QC_W'(1);
            default: ;
         endcase
      end
   end

   // Stage p1: registered update, flush and statistics outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         upd_write      <= 1'b0;
         upd_waddr      <= '0;
         upd_ctr        <= '0;
         upd_tgt_write  <= 1'b0;
         upd_target     <= '0;
         flush          <= 1'b0;
         redirect_pc    <= '0;
         mispredict_cnt <= '0;
         err_underflow  <= 1'b0;
      end else begin
         upd_write     <= pop_p0;
         upd_tgt_write <= pop_p0 && res_taken && tgt_diff_p0;
         flush         <= flush_next;
         err_underflow <= err_underflow || (res_valid && !res_ready);
         if (flush_next)
            mispredict_cnt <= sat_cnt_inc(mispredict_cnt);
         if (pop_p0) begin
            upd_waddr   <= head_p0.pc;
            upd_ctr     <= sat_ctr(head_p0.ctr, res_taken);
            upd_target  <= res_target;
            redirect_pc <= res_taken ? res_target : head_p0.pc + 32'd4;
         end
      end
   end
endmodule
